// File: rtl/freelist_mp_if.sv
// ============================================================================
// Module      : freelist_mp_if
// Description : Bundles the allocation, release, commit and status signals
//               of the multi-port physical-register free list.
//               master : rename/commit side (drives requests)
//               slave  : free list (drives grants and status)
// Ports       : alloc_req_valid, alloc_ready, alloc_preg   allocation lanes
//               free_valid, free_preg                       release lanes
//               commit_num, flush                           retire / recovery
//               free_count, overflow_err, commit_err        status
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface freelist_mp_if #(
    parameter int ALLOC_NUM      = 2,
    parameter int FREE_NUM       = 2,
    parameter int PREG_IDX_WIDTH = 6,
    parameter int LOG_NUM_PREGS  = 6
);
    localparam int CMT_W = $clog2(ALLOC_NUM + 1);

    logic [ALLOC_NUM-1:0]                alloc_req_valid;
    logic                                alloc_ready;
    logic [ALLOC_NUM*PREG_IDX_WIDTH-1:0] alloc_preg;
    logic [FREE_NUM-1:0]                 free_valid;
    logic [FREE_NUM*PREG_IDX_WIDTH-1:0]  free_preg;
    logic [CMT_W-1:0]                    commit_num;
    logic                                flush;
    logic [LOG_NUM_PREGS:0]              free_count;
    logic                                overflow_err;
    logic                                commit_err;

    modport master (
        output alloc_req_valid, free_valid, free_preg, commit_num, flush,
        input  alloc_ready, alloc_preg, free_count, overflow_err, commit_err
    );

    modport slave (
        input  alloc_req_valid, free_valid, free_preg, commit_num, flush,
        output alloc_ready, alloc_preg, free_count, overflow_err, commit_err
    );
endinterface

`default_nettype wire

// File: rtl/freelist_mp.sv
// ============================================================================
// Module      : freelist_mp
// Description : Multi-port physical-register free list for rename. Circular
//               queue of NUM_PREGS preg indices with a speculative head
//               (allocation), a committed head (retirement) and a tail
//               (release). A flush rewinds the speculative head to the
//               committed head in one cycle.
// Ports       : clock        rising-edge clock
//               reset_n      asynchronous active-low reset
//               bus          freelist_mp_if slave modport (allocation lanes,
//                            release lanes, commit/flush, status outputs)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module freelist_mp #(
    parameter int NUM_PREGS      = 64,
    parameter int LOG_NUM_PREGS  = 6,
    parameter int PREG_IDX_WIDTH = 6,
    parameter int RESERVED       = 32,
    parameter int ALLOC_NUM      = 2,
    parameter int FREE_NUM       = 2
) (
    input  wire logic      clock,
    input  wire logic      reset_n,
    freelist_mp_if.slave   bus
);

    localparam int PTR_W = LOG_NUM_PREGS + 1;
    localparam int IDX_W = LOG_NUM_PREGS;

    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W-1:0] RESET_TAIL = PTR_W'(NUM_PREGS - RESERVED);
    localparam logic [PTR_W:0]   DEPTH_EXT  = (PTR_W + 1)'(NUM_PREGS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PREG_IDX_WIDTH-1:0] queue [NUM_PREGS];
    logic [PTR_W-1:0]          spec_head;
    logic [PTR_W-1:0]          cmt_head;
    logic [PTR_W-1:0]          tail;
    logic [PTR_W-1:0]          free_count_q;
    logic                      overflow_q;
    logic                      commit_err_q;

    // ------------------------------------------------------------------
    // Allocation lane compaction: each valid lane takes the next entry
    // after the valid lanes below it, so sparse requests stay dense.
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] n_req;
    logic [IDX_W-1:0] alloc_rank [ALLOC_NUM];

    always_comb begin
        n_req = '0;
        for (int k = 0; k < ALLOC_NUM; k++) begin
            alloc_rank[k] = n_req[IDX_W-1:0];
            if (bus.alloc_req_valid[k]) begin
                n_req = n_req + PTR_ONE;
            end
        end
    end

    // Readiness uses the registered count only, so a release in this
    // cycle never feeds an allocation in the same cycle.
    logic alloc_ready;
    logic alloc_fire;

    assign alloc_ready = !bus.flush && (free_count_q >= n_req);
    assign alloc_fire  = alloc_ready && (n_req != '0);

    assign bus.alloc_ready = alloc_ready;

    for (genvar k = 0; k < ALLOC_NUM; k++) begin : g_alloc_lane
        logic [IDX_W-1:0] rd_idx;
        assign rd_idx = spec_head[IDX_W-1:0] + alloc_rank[k];
        assign bus.alloc_preg[k*PREG_IDX_WIDTH +: PREG_IDX_WIDTH] =
            bus.alloc_req_valid[k] ? queue[rd_idx] : '0;
    end

    // ------------------------------------------------------------------
    // Release lane compaction and overflow detection.
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] n_free;
    logic [IDX_W-1:0] free_rank [FREE_NUM];
    logic [IDX_W-1:0] wr_idx    [FREE_NUM];
    logic             free_drop;

    always_comb begin
        n_free = '0;
        for (int k = 0; k < FREE_NUM; k++) begin
            free_rank[k] = n_free[IDX_W-1:0];
            wr_idx[k]    = tail[IDX_W-1:0] + n_free[IDX_W-1:0];
            if (bus.free_valid[k]) begin
                n_free = n_free + PTR_ONE;
            end
        end
    end

    // One extra bit so count + releases cannot wrap before the compare.
    // A group that would overfill the queue is dropped as a whole.
    assign free_drop = ({1'b0, free_count_q} + {1'b0, n_free}) > DEPTH_EXT;

    // ------------------------------------------------------------------
    // Commit, flush and next-pointer computation.
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] commit_ext;
    logic [PTR_W-1:0] outstanding;
    logic             commit_bad;
    logic [PTR_W-1:0] cmt_next;
    logic [PTR_W-1:0] spec_next;
    logic [PTR_W-1:0] tail_next;

    assign commit_ext  = PTR_W'(bus.commit_num);
    assign outstanding = spec_head - cmt_head;
    assign commit_bad  = commit_ext > outstanding;

    // An over-commit clamps to the speculative head rather than passing it.
    assign cmt_next = commit_bad ? spec_head : (cmt_head + commit_ext);

    // Flush sees the committed head after this cycle's commit is applied.
    always_comb begin
        spec_next = spec_head;
        if (bus.flush) begin
            spec_next = cmt_next;
        end else if (alloc_fire) begin
            spec_next = spec_head + n_req;
        end
    end

    assign tail_next = free_drop ? tail : (tail + n_free);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            spec_head    <= '0;
            cmt_head     <= '0;
            tail         <= RESET_TAIL;
            free_count_q <= RESET_TAIL;
            overflow_q   <= 1'b0;
            commit_err_q <= 1'b0;
        end else begin
            spec_head    <= spec_next;
            cmt_head     <= cmt_next;
            tail         <= tail_next;
            free_count_q <= tail_next - spec_next;
            if (free_drop) begin
                overflow_q <= 1'b1;
            end
            if (commit_bad) begin
                commit_err_q <= 1'b1;
            end
        end
    end

    // Only releases write the queue; allocation and flush move pointers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                queue[i] <= (i < NUM_PREGS - RESERVED) ?
                            PREG_IDX_WIDTH'(RESERVED + i) : '0;
            end
        end else if (!free_drop) begin
            for (int k = 0; k < FREE_NUM; k++) begin
                if (bus.free_valid[k]) begin
                    queue[wr_idx[k]] <= bus.free_preg[k*PREG_IDX_WIDTH +: PREG_IDX_WIDTH];
                end
            end
        end
    end

    // free_rank is folded into wr_idx; keep the per-lane rank visible for
    // debug by tying it into nothing observable.
    logic [IDX_W-1:0] free_rank_last;
    assign free_rank_last = free_rank[FREE_NUM-1];

    assign bus.free_count   = free_count_q;
    assign bus.overflow_err = overflow_q;
    assign bus.commit_err   = commit_err_q;

endmodule

`default_nettype wire

// File: tb/tb_freelist_mp.sv
// ============================================================================
// Module      : tb_freelist_mp
// Description : Directed self-checking bench for freelist_mp with default
//               parameters. Inputs change on the falling edge; outputs are
//               sampled 1 time unit later.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_freelist_mp;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_pass;

    freelist_mp_if bus ();

    freelist_mp dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] fv,
                         input int p0, input int p1, input int cn,
                         input logic fl);
        bus.alloc_req_valid = req;
        bus.free_valid      = fv;
        bus.free_preg       = {6'(p1), 6'(p0)};
        bus.commit_num      = 2'(cn);
        bus.flush           = fl;
        #1;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 0, 0, 0, 1'b0);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        idle();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
    endtask

    function automatic int lane0();
        return int'(bus.alloc_preg[5:0]);
    endfunction

    function automatic int lane1();
        return int'(bus.alloc_preg[11:6]);
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset_n  = 1'b0;
        idle();

        // ---------------- reset state and basic allocation ----------------
        do_reset();
        check("rst_free_count", int'(bus.free_count), 32);
        check("rst_overflow", int'(bus.overflow_err), 0);
        check("rst_commit_err", int'(bus.commit_err), 0);
        drive(2'b11, 2'b00, 0, 0, 0, 1'b0);
        check("a11_ready", int'(bus.alloc_ready), 1);
        check("a11_lane0", lane0(), 32);
        check("a11_lane1", lane1(), 33);
        tick();
        drive(2'b10, 2'b00, 0, 0, 0, 1'b0);
        check("a11_free_count", int'(bus.free_count), 30);
        check("a10_ready", int'(bus.alloc_ready), 1);
        check("a10_lane1", lane1(), 34);
        check("a10_lane0", lane0(), 0);
        tick();
        idle();
        check("a10_free_count", int'(bus.free_count), 29);

        // ---------------- drain to the last entry ----------------
        for (int i = 0; i < 14; i++) begin
            drive(2'b11, 2'b00, 0, 0, 0, 1'b0);
            tick();
        end
        idle();
        check("drain_free_count", int'(bus.free_count), 1);
        drive(2'b11, 2'b00, 0, 0, 0, 1'b0);
        check("short_ready", int'(bus.alloc_ready), 0);
        tick();
        idle();
        check("short_no_change", int'(bus.free_count), 1);
        drive(2'b01, 2'b00, 0, 0, 0, 1'b0);
        check("last_ready", int'(bus.alloc_ready), 1);
        check("last_lane0", lane0(), 63);
        tick();
        idle();
        check("empty_free_count", int'(bus.free_count), 0);
        drive(2'b01, 2'b00, 0, 0, 0, 1'b0);
        check("empty_ready01", int'(bus.alloc_ready), 0);
        drive(2'b10, 2'b00, 0, 0, 0, 1'b0);
        check("empty_ready10", int'(bus.alloc_ready), 0);
        // release in the same cycle must not make allocation ready
        drive(2'b01, 2'b01, 7, 0, 0, 1'b0);
        check("no_bypass_ready", int'(bus.alloc_ready), 0);
        tick();
        idle();
        check("rel_free_count", int'(bus.free_count), 1);
        drive(2'b01, 2'b00, 0, 0, 0, 1'b0);
        check("rel_alloc_lane0", lane0(), 7);
        tick();

        // ---------------- flush after separate commit ----------------
        do_reset();
        drive(2'b11, 2'b00, 0, 0, 0, 1'b0); tick();
        drive(2'b11, 2'b00, 0, 0, 0, 1'b0); tick();
        drive(2'b00, 2'b00, 0, 0, 1, 1'b0); tick();
        drive(2'b01, 2'b00, 0, 0, 0, 1'b1);
        check("flush_blocks_alloc", int'(bus.alloc_ready), 0);
        tick();
        idle();
        check("flush_free_count", int'(bus.free_count), 31);
        drive(2'b01, 2'b00, 0, 0, 0, 1'b0);
        check("flush_alloc", lane0(), 33);
        tick();

        // ---------------- flush with same-cycle commit ----------------
        do_reset();
        drive(2'b11, 2'b00, 0, 0, 0, 1'b0); tick();
        drive(2'b11, 2'b00, 0, 0, 0, 1'b0); tick();
        drive(2'b00, 2'b00, 0, 0, 2, 1'b1); tick();
        idle();
        check("flushc_free_count", int'(bus.free_count), 30);
        drive(2'b01, 2'b00, 0, 0, 0, 1'b0);
        check("flushc_alloc", lane0(), 34);
        tick();

        // ---------------- wrap and release order ----------------
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(2'b11, 2'b00, 0, 0, 0, 1'b0);
            tick();
        end
        idle();
        check("wrap_empty", int'(bus.free_count), 0);
        drive(2'b00, 2'b11, 5, 6, 0, 1'b0); tick();
        for (int i = 0; i < 15; i++) begin
            drive(2'b00, 2'b11, 7 + 2*i, 8 + 2*i, 0, 1'b0);
            tick();
        end
        drive(2'b00, 2'b11, 37, 38, 0, 1'b0); tick();
        idle();
        check("wrap_free_count", int'(bus.free_count), 34);
        drive(2'b11, 2'b00, 0, 0, 0, 1'b0);
        check("wrap_first_l0", lane0(), 5);
        check("wrap_first_l1", lane1(), 6);
        tick();
        drive(2'b11, 2'b00, 0, 0, 0, 1'b0);
        check("wrap_second_l0", lane0(), 7);
        check("wrap_second_l1", lane1(), 8);
        tick();
        for (int i = 0; i < 14; i++) begin
            drive(2'b11, 2'b00, 0, 0, 0, 1'b0);
            check("wrap_seq_l0", lane0(), 9 + 2*i);
            check("wrap_seq_l1", lane1(), 10 + 2*i);
            tick();
        end
        drive(2'b11, 2'b00, 0, 0, 0, 1'b0);
        check("wrapped_l0", lane0(), 37);
        check("wrapped_l1", lane1(), 38);
        tick();
        idle();
        check("wrap_end_free", int'(bus.free_count), 0);

        // ---------------- overflow and commit errors ----------------
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(2'b00, 2'b11, 2*i, 2*i + 1, 0, 1'b0);
            tick();
        end
        idle();
        check("full_free_count", int'(bus.free_count), 64);
        check("full_no_overflow", int'(bus.overflow_err), 0);
        drive(2'b00, 2'b01, 50, 0, 0, 1'b0); tick();
        idle();
        check("overflow_set", int'(bus.overflow_err), 1);
        check("overflow_free_count", int'(bus.free_count), 64);
        check("overflow_no_commit_err", int'(bus.commit_err), 0);
        drive(2'b00, 2'b00, 0, 0, 1, 1'b0); tick();
        idle();
        check("commit_err_set", int'(bus.commit_err), 1);
        drive(2'b01, 2'b00, 0, 0, 0, 1'b0);
        check("dropped_not_written", lane0(), 32);
        tick();
        drive(2'b00, 2'b00, 0, 0, 0, 1'b1); tick();
        drive(2'b01, 2'b00, 0, 0, 0, 1'b0);
        check("cmt_head_kept", lane0(), 32);
        tick();
        idle();
        check("overflow_sticky", int'(bus.overflow_err), 1);
        check("commit_err_sticky", int'(bus.commit_err), 1);

        // ---------------- reset mid-operation ----------------
        do_reset();
        check("rerst_free_count", int'(bus.free_count), 32);
        check("rerst_overflow", int'(bus.overflow_err), 0);
        check("rerst_commit_err", int'(bus.commit_err), 0);
        drive(2'b01, 2'b00, 0, 0, 0, 1'b0);
        check("rerst_alloc", lane0(), 32);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/freelist_mp.md
# freelist_mp

Multi-port physical-register free list for the rename stage, and the parametrised successor of the two-port freelist. It provides ALLOC_NUM allocation lanes with an all-or-nothing ready handshake and FREE_NUM release lanes from commit. Allocations are speculative: a committed head pointer is kept so that a pipeline flush reclaims every allocation made past the last retired one in a single cycle. It also reports occupancy and sticky error flags.

## Interface
- NUM_PREGS, 64: physical registers; queue depth. Power of two.
- LOG_NUM_PREGS, 6: log2(NUM_PREGS).
- PREG_IDX_WIDTH, 6: preg index width, at least LOG_NUM_PREGS.
- RESERVED, 32: pregs 0..RESERVED-1 are architecturally mapped at reset and are not in the list.
- ALLOC_NUM, 2: allocation lanes.
- FREE_NUM, 2: release lanes.
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alloc_req_valid  in  ALLOC_NUM  per-lane allocation request.
- alloc_ready  out  1  the whole request group can be served this cycle.
- alloc_preg  out  ALLOC_NUM*PREG_IDX_WIDTH  preg assigned to each lane; lane k is bits [k*W +: W].
- free_valid  in  FREE_NUM  per-lane release.
- free_preg  in  FREE_NUM*PREG_IDX_WIDTH  released preg indices.
- commit_num  in  clog2(ALLOC_NUM+1)  number of speculative allocations retired this cycle.
- flush  in  1  restore the speculative head to the committed head.
- free_count  out  LOG_NUM_PREGS+1  registered number of entries available.
- overflow_err  out  1  sticky: a release was dropped because the list was full.
- commit_err  out  1  sticky: commit_num exceeded the outstanding speculative allocations.

## Operation
- Circular queue with NUM_PREGS entries.
- Three pointers of LOG_NUM_PREGS+1 bits each (wrap flag plus index): spec_head, cmt_head, tail.
- free_count = tail - spec_head, modulo 2^(LOG_NUM_PREGS+1). Range 0..NUM_PREGS.
- Reset:
  - entry i = RESERVED+i for i < NUM_PREGS-RESERVED; remaining entries are 0.
  - spec_head = cmt_head = 0.
  - tail = NUM_PREGS-RESERVED; when RESERVED = 0 this is flag 1, index 0.
  - free_count = NUM_PREGS-RESERVED; both error flags = 0.
- Allocation:
  - n_req = popcount(alloc_req_valid).
  - alloc_ready = !flush && (free_count >= n_req).
  - Lanes are compacted: lane k reads entry spec_head + rank(k), where rank(k) is the number of valid lanes below k.
  - alloc_preg is combinational and is only meaningful for valid lanes; invalid lanes drive 0.
  - Fire = alloc_ready && n_req > 0. Fire advances spec_head by n_req. No partial grants.
- Release:
  - Valid free lanes write compacted entries at tail + rank.
  - tail advances by popcount(free_valid).
  - If free_count + n_free > NUM_PREGS, every release that cycle is dropped and overflow_err is set.
- Commit:
  - cmt_head advances by commit_num.
  - If commit_num > spec_head - cmt_head, cmt_head is set to spec_head and commit_err is set.
- Flush:
  - spec_head <= cmt_head + commit_num. Same-cycle commit is applied first.
  - Allocation is blocked that cycle.
  - Releases in the flush cycle still take effect.
- Queue contents are never modified by allocation or flush; only releases write entries.
- Error flags stay set until reset.
- Reset mid-operation restores every pointer, entry and flag asynchronously. Requests present during reset are ignored.

## Timing
- alloc_preg and alloc_ready: zero-cycle combinational paths from alloc_req_valid and flush. The queue is read directly, with no pipeline register.
- All pointer, entry, free_count and error-flag updates occur on the next rising edge.
- A released preg becomes allocatable in the cycle after its release. alloc_ready does not see same-cycle releases (no bypass).
- After a flush, the first allocation is possible in the following cycle and returns entry cmt_head.
- Pointers wrap naturally at 2^(LOG_NUM_PREGS+1). The flag bit distinguishes full from empty.
- Simultaneous alloc fire, release, commit and flush (alloc blocked by flush): all pointer updates apply independently in one edge.

## Test plan
Default parameters throughout.
- Reset, then alloc_req_valid=11 -> alloc_ready=1, alloc_preg lanes = 32, 33. Next cycle free_count=30.
- Sparse lanes: alloc_req_valid=10 right after the above -> lane1=34, lane0=0. free_count=29 next cycle.
- Drain 31 pregs, then request 11 with free_count=1 -> alloc_ready=0 and no pointer change. Request 01 -> preg 63 granted. Next cycle free_count=0, so alloc_ready=0 for any nonzero request.
- Flush recovery:
  - From reset, allocate 32..35 and commit_num=1.
  - flush -> next-cycle allocation returns 33, free_count=31.
  - In a separate case, flush with commit_num=2 in the same cycle -> next allocation returns 34.
- Wrap and release:
  - Allocate all 32 pregs.
  - Release pregs 5, 6 (tail indices 32, 33). Continue releasing until the tail index wraps 63 -> 0 and the flag toggles.
  - Allocations then return the released pregs in release order, starting with 5, 6.
- Overflow and commit errors:
  - From reset, release 32 pregs with no allocations -> free_count=64.
  - Release one more -> dropped, overflow_err=1, free_count stays 64.
  - commit_num=1 with no outstanding allocations -> commit_err=1 and cmt_head unchanged.
